pipelined_seg_adder: RTL and testbench

Parametrised, pipelined add/subtract unit. It is the successor to the fixed 32-bit ripple adder and is sized for the 64x64 Vedic multiplier's partial-product accumulation. Operands are split into SEG-bit segments, and one segment is resolved per pipeline stage, carry registered between stages. A valid/ready handshake with full backpressure lets it sit between the partial-product generator and the final-sum register.

---
 rtl/adder_pkg.sv | 17 +
 rtl/pipelined_seg_adder_if.sv | 30 +++
 rtl/seg_add.sv | 23 ++
 rtl/pipelined_seg_adder.sv | 125 ++++++++++++
 tb/tb_pipelined_seg_adder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared sizing constants and configuration helpers for the segmented adder.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_SEG   = 16;

  // Number of pipeline stages for a given operand width and segment size.
  function automatic int unsigned nstg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

  // A legal configuration has a nonzero segment that evenly tiles the operand.
  function automatic bit seg_ok(input int unsigned width, input int unsigned seg);
    return (seg != 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/pipelined_seg_adder_if.sv
// Operand/result handshake bundle between the source, the adder and the sink.
interface pipelined_seg_adder_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/seg_add.sv
// One segment of the adder: SEG-bit a + b + ci, with the carry into the segment MSB.
module seg_add
  import adder_pkg::*;
#(
  parameter int unsigned SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cm
);

  localparam int unsigned SW1 = SEG + 1;

  // Segment sum; carry into the MSB recovered from the MSB half-sum.
  always_comb begin
    {co, s} = SW1'(a) + SW1'(b) + SW1'(ci);
    cm      = a[SEG-1] ^ b[SEG-1] ^ s[SEG-1];
  end

endmodule

// File: rtl/pipelined_seg_adder.sv
// Pipelined add/subtract: one SEG-bit segment resolved per stage, carry
// registered between stages, valid/ready handshake with full backpressure.
module pipelined_seg_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG   = DEF_SEG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_seg_adder_if.slave bus
);

  localparam int unsigned NSTG = nstg(WIDTH, SEG);

  if (!seg_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("pipelined_seg_adder: WIDTH must be a nonzero multiple of SEG");
  end

  logic             adv;
  logic [NSTG-1:0]  vld;

  // Per-stage inputs: remaining operands (low-aligned), partial sum, carry.
  logic [WIDTH-1:0] a_in [NSTG];
  logic [WIDTH-1:0] b_in [NSTG];
  logic [WIDTH-1:0] s_in [NSTG];
  logic             c_in [NSTG];

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Whole pipeline moves together unless a result is waiting on the sink.
  assign adv           = !vld[NSTG-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld[NSTG-1];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // Stage 0 operands: subtraction folds into inverted B with a forced carry-in.
  assign a_in[0] = bus.a;
  assign b_in[0] = bus.sub ? ~bus.b : bus.b;
  assign s_in[0] = '0;
  assign c_in[0] = bus.sub ? 1'b1 : bus.cin;

  // Valid chain; bubbles shift and hold exactly like beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= bus.in_valid;
      for (int k = 1; k < NSTG; k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int unsigned LO = k * SEG;
    localparam int unsigned SW = LO + SEG;

    logic [SEG-1:0] seg_s;
    logic           seg_co;
    logic           seg_cm;
    logic [SW-1:0]  sum_d;

    seg_add #(.SEG(SEG)) u_seg (
      .a  (a_in[k][SEG-1:0]),
      .b  (b_in[k][SEG-1:0]),
      .ci (c_in[k]),
      .s  (seg_s),
      .co (seg_co),
      .cm (seg_cm)
    );

    assign sum_d = SW'(s_in[k]) | (SW'(seg_s) << LO);

    if (k < NSTG - 1) begin : g_mid
      localparam int unsigned RW = WIDTH - SW;

      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;
      logic [SW-1:0] s_q;
      logic          c_q;
      logic          msb_carry_unused;

      assign msb_carry_unused = seg_cm;

      // Skew buffers keep only the segments not yet consumed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          a_q <= RW'(a_in[k] >> SEG);
          b_q <= RW'(b_in[k] >> SEG);
          s_q <= sum_d;
          c_q <= seg_co;
        end
      end

      assign a_in[k+1] = WIDTH'(a_q);
      assign b_in[k+1] = WIDTH'(b_q);
      assign s_in[k+1] = WIDTH'(s_q);
      assign c_in[k+1] = c_q;
    end else begin : g_last
      // Final stage registers the result and flags; held while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (adv) begin
          sum_q  <= WIDTH'(sum_d);
          cout_q <= seg_co;
          ovf_q  <= seg_co ^ seg_cm;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_seg_adder.sv
// Directed bench for pipelined_seg_adder: 64/16 (4 stages) and 32/32 (1 stage).
module tb_pipelined_seg_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipelined_seg_adder_if #(.WIDTH(64)) b64 ();
  pipelined_seg_adder_if #(.WIDTH(32)) b32 ();

  pipelined_seg_adder #(.WIDTH(64), .SEG(16)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b64)
  );

  pipelined_seg_adder #(.WIDTH(32), .SEG(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single beat through the chosen unit: latency, result and flags, then drain.
  task automatic one(input bit n1, input string tag,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic cin, input logic sub,
                     input logic [63:0] es, input logic ec, input logic eo);
    int   lat;
    logic ov;
    if (n1) begin
      b32.in_valid = 1'b1; b32.a = 32'(a); b32.b = 32'(b);
      b32.cin = cin; b32.sub = sub; b32.out_ready = 1'b1;
    end else begin
      b64.in_valid = 1'b1; b64.a = a; b64.b = b;
      b64.cin = cin; b64.sub = sub; b64.out_ready = 1'b1;
    end
    #1;
    chk({tag, " in_ready"}, 64'(n1 ? b32.in_ready : b64.in_ready), 64'd1);
    @(negedge clk);
    b32.in_valid = 1'b0;
    b64.in_valid = 1'b0;
    lat = 1;
    ov  = n1 ? b32.out_valid : b64.out_valid;
    while (ov !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      ov = n1 ? b32.out_valid : b64.out_valid;
    end
    chk({tag, " latency"}, 64'(lat), n1 ? 64'd1 : 64'd4);
    chk({tag, " sum"},  n1 ? 64'(b32.sum) : b64.sum, es);
    chk({tag, " cout"}, 64'(n1 ? b32.cout : b64.cout), 64'(ec));
    chk({tag, " ovf"},  64'(n1 ? b32.ovf : b64.ovf), 64'(eo));
    @(negedge clk);
    chk({tag, " drained"}, 64'(n1 ? b32.out_valid : b64.out_valid), 64'd0);
  endtask

  // Eight back-to-back beats a=i, b=3i, cin=i[0]; expect 4i+i[0] in order, one per cycle.
  task automatic stream(input bit n1);
    int   sent;
    int   recv;
    int   lat;
    logic iv;
    logic ir;
    logic ov;
    logic [63:0] s;
    lat  = n1 ? 1 : 4;
    sent = 0;
    recv = 0;
    for (int t = 0; t < 40 && recv < 8; t++) begin
      iv = (sent < 8);
      if (n1) begin
        b32.in_valid = iv; b32.a = 32'(sent); b32.b = 32'(sent * 3);
        b32.cin = 1'(sent & 1); b32.sub = 1'b0; b32.out_ready = 1'b1;
      end else begin
        b64.in_valid = iv; b64.a = 64'(sent); b64.b = 64'(sent * 3);
        b64.cin = 1'(sent & 1); b64.sub = 1'b0; b64.out_ready = 1'b1;
      end
      #1;
      ir = n1 ? b32.in_ready : b64.in_ready;
      ov = n1 ? b32.out_valid : b64.out_valid;
      s  = n1 ? 64'(b32.sum) : b64.sum;
      if (iv) begin
        chk("s3 in_ready", 64'(ir), 64'd1);
        if (ir) sent++;
      end
      if (ov === 1'b1) begin
        chk("s3 order", s, 64'(4 * recv + (recv & 1)));
        chk("s3 timing", 64'(t), 64'(recv + lat));
        recv++;
      end
      @(negedge clk);
    end
    b32.in_valid = 1'b0;
    b64.in_valid = 1'b0;
    chk("s3 count", 64'(recv), 64'd8);
  endtask

  initial begin
    int sent;
    int recv;
    int xfer [6];
    checks = 0;
    errors = 0;
    xfer   = '{4, 10, 11, 12, 13, 14};

    rst_n = 1'b0;
    b64.in_valid = 1'b0; b64.a = '0; b64.b = '0; b64.cin = 1'b0; b64.sub = 1'b0; b64.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.cin = 1'b0; b32.sub = 1'b0; b32.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst out_valid64", 64'(b64.out_valid), 64'd0);
    chk("rst sum64", b64.sum, 64'd0);
    chk("rst out_valid32", 64'(b32.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", 64'(b64.in_ready), 64'd1);
    chk("post-rst cout", 64'(b64.cout), 64'd0);
    chk("post-rst ovf", 64'(b64.ovf), 64'd0);
    @(negedge clk);

    // Scenarios 1-2: arithmetic corners on the 4-stage unit
    one(1'b0, "s1 ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    one(1'b0, "s2 pos ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
        64'h8000_0000_0000_0000, 1'b0, 1'b1);
    one(1'b0, "s2 sub borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    one(1'b0, "sub cin ignored", 64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0);
    one(1'b0, "neg ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
        64'd0, 1'b1, 1'b1);
    one(1'b0, "seg carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    one(1'b0, "cin ripple", 64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
        64'h0001_0000_0000_0000, 1'b0, 1'b0);

    // Scenario 3: streaming
    stream(1'b0);

    // Scenario 4: six beats, sink stalls for cycles 5-9
    sent = 0;
    recv = 0;
    for (int t = 0; t < 40 && recv < 6; t++) begin
      b64.out_ready = !(t >= 5 && t <= 9);
      b64.in_valid  = (sent < 6);
      b64.a   = (64'(sent) << 48) | 64'h0000_FFFF_FFFF_FFFF;
      b64.b   = 64'd1;
      b64.cin = 1'b0;
      b64.sub = 1'b0;
      #1;
      if (t >= 5 && t <= 9) begin
        chk("s4 stall in_ready", 64'(b64.in_ready), 64'd0);
        chk("s4 stall out_valid", 64'(b64.out_valid), 64'd1);
        chk("s4 stall held sum", b64.sum, 64'h0002_0000_0000_0000);
      end
      if (b64.in_valid && b64.in_ready) sent++;
      if (b64.out_valid === 1'b1 && b64.out_ready) begin
        chk("s4 order", b64.sum, 64'(recv + 1) << 48);
        chk("s4 xfer time", 64'(t), 64'(xfer[recv]));
        recv++;
      end
      @(negedge clk);
    end
    b64.in_valid  = 1'b0;
    b64.out_ready = 1'b1;
    chk("s4 sent", 64'(sent), 64'd6);
    chk("s4 recv", 64'(recv), 64'd6);
    #1;
    chk("s4 no duplicate", 64'(b64.out_valid), 64'd0);
    @(negedge clk);

    // Scenario 5: async reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      b64.in_valid = 1'b1;
      b64.a   = 64'h1234_5678_0000_0000 + 64'(i);
      b64.b   = 64'h10;
      b64.cin = 1'b0;
      b64.sub = 1'b0;
      b64.out_ready = 1'b1;
      @(negedge clk);
    end
    b64.in_valid  = 1'b0;
    b64.out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("s5 head present", 64'(b64.out_valid), 64'd1);
    chk("s5 head sum", b64.sum, 64'h1234_5678_0000_0010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s5 async out_valid", 64'(b64.out_valid), 64'd0);
    chk("s5 async sum", b64.sum, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b64.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("s5 no stale beat", 64'(b64.out_valid), 64'd0);
      @(negedge clk);
    end

    // Scenario 6: single-stage 32-bit unit
    one(1'b1, "s6 ripple", 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    one(1'b1, "s6 pos ovf", 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
    one(1'b1, "s6 sub borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0);
    stream(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
